dds_phase_accum: RTL and testbench

//  Consumer end of the DDS control-word interface: accepts PhaseInc/FreqMod/PhaseMod words through
//  a valid/ready handshake and runs the 32-bit phase accumulator that drives the sine LUT / DAC path.

---
 rtl/dds_phase_accum.sv | 171 +++++++++++++++++
 tb/tb_dds_phase_accum.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_accum.sv
// DDS phase accumulator with a valid/ready control-word port.
// New frequency and phase words take effect either on the next cycle or at the next
// accumulator wrap. Deferring them to the wrap lets the frequency change without a glitch.
module dds_phase_accum #(
   parameter int ACC_W = 32,
   parameter int PM_W  = 16,
   parameter int OUT_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [ACC_W-1:0] cfg_phase_inc,
   input  logic [ACC_W-1:0] cfg_freq_mod,
   input  logic [PM_W-1:0]  cfg_phase_mod,
   input  logic             cfg_defer,
   output logic [OUT_W-1:0] phase_out,
   output logic             phase_valid,
   output logic             wrap_pulse,
   output logic             sq_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] inc_q, inc_d;
   logic [ACC_W-1:0] fmod_q, fmod_d;
   logic [PM_W-1:0]  pm_q, pm_d;
   logic [ACC_W-1:0] shInc_q, shInc_d;
   logic [ACC_W-1:0] shFmod_q, shFmod_d;
   logic [PM_W-1:0]  shPm_q, shPm_d;
   logic [OUT_W-1:0] phase_q, phase_d;
   logic             pv_q, pv_d;
   logic             wrap_q, wrap_d;

   logic             accept;
   logic [ACC_W-1:0] step;
   logic [ACC_W:0]   sum;
   logic             carry;
   logic [PM_W-1:0]  modPhase;

   // Ready depends only on the state, so it never combinationally depends on cfg_valid.
   assign cfg_ready = (state_q != PEND);
   assign accept    = cfg_valid & cfg_ready;
   assign step      = inc_q + fmod_q;
   assign sum       = {1'b0, acc_q} + {1'b0, step};
   assign carry     = sum[ACC_W];
   assign modPhase  = acc_q[ACC_W-1 -: PM_W] + pm_q;

   assign phase_out   = phase_q;
   assign phase_valid = pv_q;
   assign wrap_pulse  = wrap_q;
   assign sq_out      = phase_q[OUT_W-1];

   // Next-state logic: the control FSM, the active and shadow word registers, and the output pipeline.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      inc_d    = inc_q;
      fmod_d   = fmod_q;
      pm_d     = pm_q;
      shInc_d  = shInc_q;
      shFmod_d = shFmod_q;
      shPm_d   = shPm_q;
      phase_d  = OUT_W'(modPhase >> (PM_W - OUT_W));
      pv_d     = 1'b1;
      wrap_d   = 1'b0;

      if (accept) begin
         shInc_d  = cfg_phase_inc;
         shFmod_d = cfg_freq_mod;
         shPm_d   = cfg_phase_mod;
      end

      case (state_q)
         IDLE: begin
            acc_d   = '0;
            phase_d = '0;
            pv_d    = 1'b0;
            if (accept) begin
               inc_d  = cfg_phase_inc;
               fmod_d = cfg_freq_mod;
               pm_d   = cfg_phase_mod;
            end
            if (en) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!en) begin
               acc_d   = '0;
               state_d = IDLE;
               if (accept) begin
                  inc_d  = cfg_phase_inc;
                  fmod_d = cfg_freq_mod;
                  pm_d   = cfg_phase_mod;
               end
            end else begin
               acc_d  = sum[ACC_W-1:0];
               wrap_d = carry;
               if (accept) begin
                  if (cfg_defer) begin
                     state_d = PEND;
                  end else begin
                     inc_d  = cfg_phase_inc;
                     fmod_d = cfg_freq_mod;
                     pm_d   = cfg_phase_mod;
                  end
               end
            end
         end
         PEND: begin
            if (!en) begin
               acc_d   = '0;
               state_d = IDLE;
               inc_d   = shInc_q;
               fmod_d  = shFmod_q;
               pm_d    = shPm_q;
            end else begin
               acc_d  = sum[ACC_W-1:0];
               wrap_d = carry;
               if (carry) begin
                  inc_d   = shInc_q;
                  fmod_d  = shFmod_q;
                  pm_d    = shPm_q;
                  state_d = RUN;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. Reset clears every word, so the block restarts silent in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         inc_q    <= '0;
         fmod_q   <= '0;
         pm_q     <= '0;
         shInc_q  <= '0;
         shFmod_q <= '0;
         shPm_q   <= '0;
         phase_q  <= '0;
         pv_q     <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         inc_q    <= inc_d;
         fmod_q   <= fmod_d;
         pm_q     <= pm_d;
         shInc_q  <= shInc_d;
         shFmod_q <= shFmod_d;
         shPm_q   <= shPm_d;
         phase_q  <= phase_d;
         pv_q     <= pv_d;
         wrap_q   <= wrap_d;
      end
   end

endmodule

// File: tb/tb_dds_phase_accum.sv
// Testbench for dds_phase_accum: a vector table, hand-written corner sequences,
// and randomized traffic compared against a cycle-level arithmetic model.
module tb_dds_phase_accum;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        cfgValid;
   logic        cfgReady;
   logic [31:0] cfgInc;
   logic [31:0] cfgFmod;
   logic [15:0] cfgPm;
   logic        cfgDefer;
   logic [11:0] phaseOut;
   logic        phaseValid;
   logic        wrapPulse;
   logic        sqOut;

   int checks   = 0;
   int failures = 0;

   // Reference model state: running/pending flags plus plain integer phase arithmetic.
   bit          mRun;
   bit          mPend;
   logic [31:0] mAcc, mInc, mFmod, mShInc, mShFmod;
   logic [15:0] mPm, mShPm;
   logic [11:0] xPhase;
   bit          xValid;
   bit          xWrap;

   typedef struct {
      logic        en;
      logic        valid;
      logic        defer;
      logic [31:0] inc;
      logic [31:0] fmod;
      logic [15:0] pm;
      logic [11:0] expPhase;
      logic        expValid;
      logic        expWrap;
      logic        expReady;
   } vec_t;

   vec_t vecs[14];

   dds_phase_accum dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .cfg_valid    (cfgValid),
      .cfg_ready    (cfgReady),
      .cfg_phase_inc(cfgInc),
      .cfg_freq_mod (cfgFmod),
      .cfg_phase_mod(cfgPm),
      .cfg_defer    (cfgDefer),
      .phase_out    (phaseOut),
      .phase_valid  (phaseValid),
      .wrap_pulse   (wrapPulse),
      .sq_out       (sqOut)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mRun    = 0;
      mPend   = 0;
      mAcc    = 0;
      mInc    = 0;
      mFmod   = 0;
      mPm     = 0;
      mShInc  = 0;
      mShFmod = 0;
      mShPm   = 0;
      xPhase  = 0;
      xValid  = 0;
      xWrap   = 0;
   endtask

   // One clock of the model: the accumulator is a 64-bit integer that wraps at 2^32.
   task automatic modelStep();
      longint      nxt;
      logic [31:0] stepv;
      bit          took;
      bit          wrapped;
      took    = cfgValid && !mPend;
      stepv   = mInc + mFmod;
      nxt     = longint'(mAcc) + longint'(stepv);
      wrapped = (nxt > 64'd4294967295);
      xPhase  = mRun ? 12'((((mAcc >> 16) + 32'(mPm)) % 65536) >> 4) : 12'h0;
      xValid  = mRun;
      xWrap   = mRun && en && wrapped;
      if (!mRun) begin
         mAcc = 0;
         if (took) begin
            mInc = cfgInc; mFmod = cfgFmod; mPm = cfgPm;
         end
         mRun = en;
      end else if (!en) begin
         mAcc = 0;
         mRun = 0;
         if (mPend) begin
            mInc = mShInc; mFmod = mShFmod; mPm = mShPm; mPend = 0;
         end
         if (took) begin
            mInc = cfgInc; mFmod = cfgFmod; mPm = cfgPm;
         end
      end else begin
         mAcc = 32'(nxt % 64'd4294967296);
         if (mPend) begin
            if (wrapped) begin
               mInc = mShInc; mFmod = mShFmod; mPm = mShPm; mPend = 0;
            end
         end else if (took) begin
            if (cfgDefer) begin
               mShInc = cfgInc; mShFmod = cfgFmod; mShPm = cfgPm; mPend = 1;
            end else begin
               mInc = cfgInc; mFmod = cfgFmod; mPm = cfgPm;
            end
         end
      end
   endtask

   // Advance one clock, update the model, then compare all outputs 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      if (rst) modelReset();
      else modelStep();
      #1;
      checkOutput("phase_out", 32'(phaseOut), 32'(xPhase));
      checkOutput("phase_valid", 32'(phaseValid), 32'(xValid));
      checkOutput("wrap_pulse", 32'(wrapPulse), 32'(xWrap));
      checkOutput("sq_out", 32'(sqOut), 32'(xPhase[11]));
      checkOutput("cfg_ready", 32'(cfgReady), 32'(!mPend));
   endtask

   task automatic applyStimulus(input logic e, input logic v, input logic [31:0] inc,
                                input logic [31:0] fm, input logic [15:0] pm, input logic d);
      en       = e;
      cfgValid = v;
      cfgInc   = inc;
      cfgFmod  = fm;
      cfgPm    = pm;
      cfgDefer = d;
      tick();
   endtask

   task automatic doReset(input int cycles);
      rst = 1'b1;
      modelReset();
      en = 0; cfgValid = 0; cfgInc = 0; cfgFmod = 0; cfgPm = 0; cfgDefer = 0;
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   initial begin
      int wrapCount;

      vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 16'h0000, 12'h000, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0000, 12'h000, 1'b0, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0000, 12'h000, 1'b1, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0000, 12'h400, 1'b1, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0000, 12'h800, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0000, 12'hC00, 1'b1, 1'b1, 1'b1};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 16'h8000, 12'h000, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0000, 12'hC00, 1'b1, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0000, 12'h000, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0000, 12'h400, 1'b1, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 16'h0000, 12'h800, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0000, 12'h400, 1'b1, 1'b0, 1'b1};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0000, 12'h400, 1'b1, 1'b0, 1'b1};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0000, 12'h400, 1'b1, 1'b0, 1'b1};

      // Reset held for five cycles: all outputs are quiet and the block is ready.
      doReset(5);
      checkOutput("rst_phase_out", 32'(phaseOut), 32'h0);
      checkOutput("rst_phase_valid", 32'(phaseValid), 32'h0);
      checkOutput("rst_wrap_pulse", 32'(wrapPulse), 32'h0);
      checkOutput("rst_cfg_ready", 32'(cfgReady), 32'h1);

      // 200 kHz word for 1000 cycles: 1000*85899346 = 20*2^32 + 80.
      doReset(2);
      applyStimulus(1'b0, 1'b1, 32'd85899346, 32'h0, 16'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      wrapCount = 0;
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
         if (wrapPulse) wrapCount++;
      end
      checkOutput("t2_acc", dut.acc_q, 32'd80);
      checkOutput("t2_wraps", 32'(wrapCount), 32'd20);

      // Quarter-turn stepping, a phase offset, and finally a net step of zero.
      doReset(2);
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].en, vecs[i].valid, vecs[i].inc, vecs[i].fmod, vecs[i].pm, vecs[i].defer);
         checkOutput($sformatf("vec%0d_phase", i), 32'(phaseOut), 32'(vecs[i].expPhase));
         checkOutput($sformatf("vec%0d_valid", i), 32'(phaseValid), 32'(vecs[i].expValid));
         checkOutput($sformatf("vec%0d_wrap", i), 32'(wrapPulse), 32'(vecs[i].expWrap));
         checkOutput($sformatf("vec%0d_ready", i), 32'(cfgReady), 32'(vecs[i].expReady));
      end

      // A deferred word accepted mid-period takes effect only after the next wrap.
      doReset(2);
      applyStimulus(1'b0, 1'b1, 32'h4000_0000, 32'h0, 16'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h2000_0000, 32'h0, 16'h0, 1'b1);
      checkOutput("t4_ready_pend0", 32'(cfgReady), 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      checkOutput("t4_ready_pend1", 32'(cfgReady), 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      checkOutput("t4_ready_wrap", 32'(cfgReady), 32'h1);
      checkOutput("t4_wrap", 32'(wrapPulse), 32'h1);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      checkOutput("t4_phase0", 32'(phaseOut), 32'h000);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      checkOutput("t4_phase1", 32'(phaseOut), 32'h200);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      checkOutput("t4_phase2", 32'(phaseOut), 32'h400);

      // A deferred word accepted in the same cycle as a carry waits for the following carry.
      doReset(2);
      applyStimulus(1'b0, 1'b1, 32'h4000_0000, 32'h0, 16'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h2000_0000, 32'h0, 16'h0, 1'b1);
      checkOutput("t6_carry_accept_wrap", 32'(wrapPulse), 32'h1);
      checkOutput("t6_carry_accept_ready", 32'(cfgReady), 32'h0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
         checkOutput($sformatf("t6_still_pend%0d", i), 32'(cfgReady), 32'h0);
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      checkOutput("t6_applied_ready", 32'(cfgReady), 32'h1);
      checkOutput("t6_applied_wrap", 32'(wrapPulse), 32'h1);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      checkOutput("t6_new_step", 32'(phaseOut), 32'h200);

      // An asynchronous reset while a word is pending discards it and clears every word.
      applyStimulus(1'b1, 1'b1, 32'h1000_0000, 32'h0, 16'h1234, 1'b1);
      #2;
      rst = 1'b1;
      modelReset();
      #1;
      checkOutput("t6_async_ready", 32'(cfgReady), 32'h1);
      checkOutput("t6_async_valid", 32'(phaseValid), 32'h0);
      checkOutput("t6_async_phase", 32'(phaseOut), 32'h0);
      en = 0; cfgValid = 0;
      tick();
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      checkOutput("t6_zero_words_phase", 32'(phaseOut), 32'h0);
      checkOutput("t6_zero_words_valid", 32'(phaseValid), 32'h1);

      // Dropping en while a word is pending applies it at once and clears the phase.
      applyStimulus(1'b1, 1'b1, 32'h4000_0000, 32'h0, 16'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h1000_0000, 32'h0, 16'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      checkOutput("t6_en_off_ready", 32'(cfgReady), 32'h1);
      checkOutput("t6_en_off_acc", dut.acc_q, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      checkOutput("t6_shadow_step", 32'(phaseOut), 32'h100);

      // Randomized traffic: occasional enable drops, mixed deferred and immediate words.
      doReset(2);
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 15) != 0),
                       ($urandom_range(0, 2) == 0),
                       $urandom(),
                       ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom(),
                       16'($urandom()),
                       1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
